// File: rtl/ma_frame_sequencer_if.sv
// Sample-stream, moving_average side-channel and tagged-output bundle for ma_frame_sequencer.
// The slave modport is the sequencer; the master modport is its environment (source, filter, consumer).
interface ma_frame_sequencer_if #(
  parameter int FRAME_W = 16
);
  logic [15:0]        idata;
  logic               ivalid;
  logic               iready;
  logic [15:0]        ma_idata;
  logic               ma_ivalid;
  logic [31:0]        ma_iidx;
  logic               ma_rstn;
  logic [15:0]        ma_odata;
  logic               ma_ovalid;
  logic [31:0]        ma_oidx;
  logic [15:0]        odata;
  logic               ovalid;
  logic [31:0]        oidx;
  logic [FRAME_W-1:0] oframe;
  logic               oframe_done;
  logic               oerr;

  modport slave (
    input  idata, ivalid, ma_odata, ma_ovalid, ma_oidx,
    output iready, ma_idata, ma_ivalid, ma_iidx, ma_rstn,
    output odata, ovalid, oidx, oframe, oframe_done, oerr
  );

  modport master (
    output idata, ivalid, ma_odata, ma_ovalid, ma_oidx,
    input  iready, ma_idata, ma_ivalid, ma_iidx, ma_rstn,
    input  odata, ovalid, oidx, oframe, oframe_done, oerr
  );
endinterface

// File: rtl/ma_frame_sequencer.sv
// Frames a sample stream for moving_average: index stamping, drain-wait with timeout,
// inter-frame filter reset, and frame-number tagging of the filtered outputs.
module ma_frame_sequencer #(
  parameter int FRAME_LEN  = 256,
  parameter int RST_CYCLES = 1,
  parameter int DRAIN_TMO  = 64,
  parameter int FRAME_W    = 16
) (
  input  logic                  iclk,
  input  logic                  irstn,
  ma_frame_sequencer_if.slave   io_seq
);
  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam int RC_W  = $clog2(RST_CYCLES + 1);
  localparam int TMO_W = $clog2(DRAIN_TMO + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
  localparam logic [31:0]      LAST_IDX = 32'(FRAME_LEN - 1);

  typedef enum logic [1:0] {S_FLUSH, S_FEED, S_DRAIN} state_t;

  state_t             r_state, w_state_nxt;
  logic [RC_W-1:0]    r_rcnt;
  logic [CNT_W-1:0]   r_cnt;
  logic [TMO_W-1:0]   r_tmr;
  logic [FRAME_W-1:0] r_frame;
  logic               r_ma_rstn, r_ma_ivalid;
  logic [15:0]        r_ma_idata;
  logic [31:0]        r_ma_iidx;
  logic               r_ovalid, r_oframe_done, r_oerr;
  logic [15:0]        r_odata;
  logic [31:0]        r_oidx;
  logic [FRAME_W-1:0] r_oframe;
  logic               w_accept, w_last_acc, w_last_out, w_tmo, w_flush_done;

  always_comb begin
    w_accept     = (r_state == S_FEED) && io_seq.ivalid;
    w_last_acc   = w_accept && (r_cnt == LAST_CNT);
    w_last_out   = (r_state == S_DRAIN) && io_seq.ma_ovalid && (io_seq.ma_oidx == LAST_IDX);
    // A genuine last output wins over a timeout landing on the same cycle.
    w_tmo        = (r_state == S_DRAIN) && !w_last_out && (r_tmr == TMO_W'(DRAIN_TMO - 1));
    w_flush_done = (r_state == S_FLUSH) && (r_rcnt == RC_W'(1));
    w_state_nxt  = r_state;
    case (r_state)
      S_FLUSH: if (w_flush_done)            w_state_nxt = S_FEED;
      S_FEED:  if (w_last_acc)              w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_last_out || w_tmo)     w_state_nxt = S_FLUSH;
      default:                              w_state_nxt = S_FLUSH;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (!irstn) begin
      r_state       <= S_FLUSH;
      r_rcnt        <= RC_W'(RST_CYCLES);
      r_cnt         <= '0;
      r_tmr         <= '0;
      r_frame       <= '0;
      r_ma_rstn     <= 1'b0;
      r_ma_ivalid   <= 1'b0;
      r_ma_idata    <= '0;
      r_ma_iidx     <= '0;
      r_ovalid      <= 1'b0;
      r_odata       <= '0;
      r_oidx        <= '0;
      r_oframe      <= '0;
      r_oframe_done <= 1'b0;
      r_oerr        <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ma_rstn   <= (w_state_nxt != S_FLUSH);
      r_ma_ivalid <= w_accept;
      if (w_state_nxt == S_FLUSH && r_state != S_FLUSH)
        r_rcnt <= RC_W'(RST_CYCLES);
      else if (r_state == S_FLUSH)
        r_rcnt <= r_rcnt - 1'b1;

      if (r_state == S_FLUSH) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_ma_idata <= io_seq.idata;
        r_ma_iidx  <= 32'(r_cnt);
        r_cnt      <= w_last_acc ? '0 : r_cnt + 1'b1;
      end

      r_tmr <= (r_state == S_DRAIN) ? r_tmr + 1'b1 : '0;

      // Filter outputs are meaningless while it is held in reset.
      if (r_state == S_FLUSH) begin
        r_ovalid <= 1'b0;
      end else begin
        r_ovalid <= io_seq.ma_ovalid;
        r_odata  <= io_seq.ma_odata;
        r_oidx   <= io_seq.ma_oidx;
        r_oframe <= r_frame;
      end
      r_oframe_done <= w_last_out;

      if (w_last_out || w_tmo) r_frame <= r_frame + 1'b1;
      if (w_tmo)               r_oerr  <= 1'b1;
    end
  end

  assign io_seq.iready      = (r_state == S_FEED);
  assign io_seq.ma_idata    = r_ma_idata;
  assign io_seq.ma_ivalid   = r_ma_ivalid;
  assign io_seq.ma_iidx     = r_ma_iidx;
  assign io_seq.ma_rstn     = r_ma_rstn;
  assign io_seq.odata       = r_odata;
  assign io_seq.ovalid      = r_ovalid;
  assign io_seq.oidx        = r_oidx;
  assign io_seq.oframe      = r_oframe;
  assign io_seq.oframe_done = r_oframe_done;
  assign io_seq.oerr        = r_oerr;
endmodule

// File: tb/tb_ma_frame_sequencer.sv
// Bench for ma_frame_sequencer: stub 4-tap averaging filter, frame-level reference model,
// a cycle table for the first frame, and hand sequences for gaps, timeout and mid-frame reset.
module tb_ma_frame_sequencer;
  localparam int FL  = 4;
  localparam int TMO = 8;
  localparam int FW  = 16;

  logic iclk = 1'b0;
  logic irstn;
  always #5 iclk = ~iclk;

  ma_frame_sequencer_if #(.FRAME_W(FW)) bus ();

  ma_frame_sequencer #(
    .FRAME_LEN(FL), .RST_CYCLES(1), .DRAIN_TMO(TMO), .FRAME_W(FW)
  ) dut (
    .iclk(iclk), .irstn(irstn), .io_seq(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Stub filter: 2-cycle latency average of the last 4 in-frame samples; can hide the last index.
  bit          suppress = 1'b0;
  logic [15:0] h0, h1, h2, s1d, s2d;
  logic        s1v, s2v;
  logic [31:0] s1i, s2i;
  always @(posedge iclk) begin
    if (bus.ma_rstn !== 1'b1) begin
      h0 <= '0; h1 <= '0; h2 <= '0;
      s1v <= 1'b0; s2v <= 1'b0; s1d <= '0; s2d <= '0; s1i <= '0; s2i <= '0;
    end else begin
      s2v <= s1v; s2d <= s1d; s2i <= s1i;
      if (bus.ma_ivalid) begin
        h0 <= bus.ma_idata; h1 <= h0; h2 <= h1;
        s1v <= !(suppress && bus.ma_iidx == 32'(FL - 1));
        s1d <= 16'((18'(bus.ma_idata) + 18'(h0) + 18'(h1) + 18'(h2)) >> 2);
        s1i <= bus.ma_iidx;
      end else begin
        s1v <= 1'b0;
      end
    end
  end
  assign bus.ma_ovalid = s2v;
  assign bus.ma_odata  = s2d;
  assign bus.ma_oidx   = s2i;

  // Reference model: per-frame sample list and expected output stream.
  typedef struct { int unsigned frame; int unsigned idx; logic [15:0] data; } exp_t;
  typedef struct { logic [31:0] idx; logic [15:0] data; } ma_t;
  logic [15:0] cur[$];
  exp_t        expq[$];
  ma_t         maq[$];
  int unsigned mframe = 0;
  int          exp_done = 0, got_done = 0;
  bit          mon_en = 1'b0;
  int          m_idx, m_sum;
  exp_t        e;
  ma_t         m;

  always @(negedge iclk) begin
    if (mon_en && irstn === 1'b1) begin
      if (bus.ma_ivalid === 1'b1) begin
        if (maq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL ma_ivalid_unexpected: got iidx %0d, expected no sample", bus.ma_iidx);
        end else begin
          m = maq.pop_front();
          chk("ma_iidx", bus.ma_iidx, m.idx);
          chk("ma_idata", bus.ma_idata, m.data);
        end
      end
      if (bus.ovalid === 1'b1) begin
        if (expq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL ovalid_unexpected: got oidx %0d, expected no output", bus.oidx);
        end else begin
          e = expq.pop_front();
          chk("oidx", bus.oidx, e.idx);
          chk("odata", bus.odata, e.data);
          chk("oframe", bus.oframe, e.frame);
          chk("oframe_done", bus.oframe_done, e.idx == FL - 1);
        end
      end
      if (bus.oframe_done === 1'b1) begin
        got_done++;
        chk("done_without_ovalid", bus.ovalid, 1'b1);
      end
      if (bus.ivalid && bus.iready === 1'b1) begin
        m_idx = cur.size();
        cur.push_back(bus.idata);
        maq.push_back('{idx: 32'(m_idx), data: bus.idata});
        m_sum = 0;
        for (int k = 0; k < 4; k++) if (m_idx - k >= 0) m_sum += int'(cur[m_idx - k]);
        if (!(suppress && m_idx == FL - 1)) begin
          expq.push_back('{frame: mframe, idx: m_idx, data: 16'(m_sum >> 2)});
          if (m_idx == FL - 1) exp_done++;
        end
        if (m_idx == FL - 1) begin
          cur.delete();
          mframe = (mframe + 1) % (1 << FW);
        end
      end
    end
  end

  // All tasks start and end just after a rising edge.
  task automatic push_sample(input logic [15:0] d);
    bit acc = 1'b0;
    bus.ivalid = 1'b1;
    bus.idata  = d;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge iclk);
      acc = (bus.iready === 1'b1);
      @(posedge iclk); #1;
    end
    if (!acc) begin
      n_tests++; n_fail++;
      $display("FAIL push_timeout: got no accept, expected accept within 50 cycles");
    end
    bus.ivalid = 1'b0;
  endtask

  task automatic wait_done(input int ef);
    bit found = 1'b0;
    for (int t = 0; t < 40 && !found; t++) begin
      @(negedge iclk);
      if (bus.oframe_done === 1'b1) found = 1'b1;
      else begin @(posedge iclk); #1; end
    end
    chk("frame_done_seen", found, 1'b1);
    if (found) begin
      chk("done_oframe", bus.oframe, ef);
      chk("done_oidx", bus.oidx, FL - 1);
      chk("done_ma_rstn_low", bus.ma_rstn, 1'b0);
      chk("done_iready_low", bus.iready, 1'b0);
      @(posedge iclk); #1;
      @(negedge iclk);
      chk("flush_ma_rstn_high", bus.ma_rstn, 1'b1);
      chk("flush_iready_high", bus.iready, 1'b1);
      @(posedge iclk); #1;
    end
  endtask

  task automatic chk_reset_state();
    chk("rst_iready", bus.iready, 1'b0);
    chk("rst_ma_rstn", bus.ma_rstn, 1'b0);
    chk("rst_ma_ivalid", bus.ma_ivalid, 1'b0);
    chk("rst_ma_idata", bus.ma_idata, 0);
    chk("rst_ma_iidx", bus.ma_iidx, 0);
    chk("rst_ovalid", bus.ovalid, 1'b0);
    chk("rst_odata", bus.odata, 0);
    chk("rst_oidx", bus.oidx, 0);
    chk("rst_oframe", bus.oframe, 0);
    chk("rst_oframe_done", bus.oframe_done, 1'b0);
    chk("rst_oerr", bus.oerr, 1'b0);
  endtask

  typedef struct {
    logic ivalid; logic [15:0] idata;
    logic e_rdy; logic e_mav; logic e_rstn; logic [15:0] e_mad; logic [31:0] e_mai;
  } vec_t;
  vec_t tbl[7];

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100us");
    $fatal(1);
  end

  initial begin
    bit prev;
    bit pat[7];
    int done_before;
    tbl[0] = '{1'b1, 16'd0,  1'b0, 1'b0, 1'b0, 16'd0, 32'd0};
    tbl[1] = '{1'b1, 16'd0,  1'b1, 1'b0, 1'b1, 16'd0, 32'd0};
    tbl[2] = '{1'b1, 16'd2,  1'b1, 1'b1, 1'b1, 16'd0, 32'd0};
    tbl[3] = '{1'b1, 16'd4,  1'b1, 1'b1, 1'b1, 16'd2, 32'd1};
    tbl[4] = '{1'b1, 16'd6,  1'b1, 1'b1, 1'b1, 16'd4, 32'd2};
    tbl[5] = '{1'b1, 16'd99, 1'b0, 1'b1, 1'b1, 16'd6, 32'd3};
    tbl[6] = '{1'b0, 16'd0,  1'b0, 1'b0, 1'b1, 16'd6, 32'd3};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    irstn = 1'b0; bus.ivalid = 1'b0; bus.idata = '0;
    @(posedge iclk); #1;
    @(negedge iclk);
    chk_reset_state();
    @(posedge iclk); #1;
    irstn = 1'b1; mon_en = 1'b1;

    // First frame, cycle by cycle from reset release.
    for (int r = 0; r < 7; r++) begin
      bus.ivalid = tbl[r].ivalid;
      bus.idata  = tbl[r].idata;
      @(negedge iclk);
      chk($sformatf("tbl%0d_iready", r), bus.iready, tbl[r].e_rdy);
      chk($sformatf("tbl%0d_ma_ivalid", r), bus.ma_ivalid, tbl[r].e_mav);
      chk($sformatf("tbl%0d_ma_rstn", r), bus.ma_rstn, tbl[r].e_rstn);
      chk($sformatf("tbl%0d_ma_idata", r), bus.ma_idata, tbl[r].e_mad);
      chk($sformatf("tbl%0d_ma_iidx", r), bus.ma_iidx, tbl[r].e_mai);
      @(posedge iclk); #1;
    end
    wait_done(0);

    push_sample(16'd4); push_sample(16'd8); push_sample(16'd12); push_sample(16'd16);
    wait_done(1);

    // Upstream gaps: ma_ivalid follows each accept by one cycle.
    prev = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus.ivalid = (k < 7) ? pat[k] : 1'b0;
      bus.idata  = 16'(100 + 7 * k);
      @(negedge iclk);
      chk($sformatf("gap%0d_ma_ivalid", k), bus.ma_ivalid, prev);
      prev = bus.ivalid & bus.iready;
      @(posedge iclk); #1;
    end
    bus.ivalid = 1'b0;
    wait_done(2);
    chk("oerr_clear_before_tmo", bus.oerr, 1'b0);

    // Filter never reports the last index: drain must time out.
    suppress = 1'b1;
    done_before = got_done;
    for (int i = 0; i < FL; i++) push_sample(16'($urandom));
    begin
      bit seen = 1'b0;
      for (int t = 0; t < 40 && !seen; t++) begin
        @(negedge iclk);
        if (bus.oerr === 1'b1) seen = 1'b1;
        @(posedge iclk); #1;
      end
      chk("tmo_oerr_set", seen, 1'b1);
    end
    suppress = 1'b0;
    chk("tmo_no_frame_done", got_done, done_before);
    for (int i = 0; i < FL; i++) push_sample(16'($urandom));
    wait_done(4);
    chk("oerr_sticky", bus.oerr, 1'b1);

    // Randomized frames with random inter-sample gaps.
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < FL; i++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge iclk); #1; end
        push_sample(16'($urandom));
      end
      wait_done(5 + f);
    end

    // Reset in the middle of a frame.
    push_sample(16'h1111); push_sample(16'h2222);
    chk("pre_reset_done_count", got_done, exp_done);
    mon_en = 1'b0;
    irstn = 1'b0;
    @(posedge iclk); #1;
    @(negedge iclk);
    chk_reset_state();
    cur.delete(); expq.delete(); maq.delete();
    mframe = 0; exp_done = 0; got_done = 0;
    @(posedge iclk); #1;
    irstn = 1'b1; mon_en = 1'b1;
    for (int i = 0; i < FL; i++) push_sample(16'($urandom));
    wait_done(0);

    repeat (4) begin @(posedge iclk); #1; end
    chk("end_expq_empty", expq.size(), 0);
    chk("end_maq_empty", maq.size(), 0);
    chk("end_done_count", got_done, exp_done);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
